// File: rtl/act_mem_output_writer.sv
// Purpose: packs result activations (scalar or N-lane beats) into N-word rows and
//          writes them sequentially to the activation memory; owns the ping-pong
//          input/output buffer pointers and swaps them at layer end.
// Latency: row write (wr_en/wr_addr/wr_word) registered, one cycle after the
//          accepting edge of the beat that completes the row; done 2 cycles after
//          the final accepted beat.
// Backpressure: memory never stalls; in_ready is high only in RUN while elements
//          remain, and in_valid low simply holds all state.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   start, cfg_num_elems,
//   cfg_vector_mode, cfg_swap       layer start pulse and configuration (sampled in IDLE)
//   in_valid, in_ready, in_data     activation input stream, lane k at [k*W +: W]
//   wr_en, wr_addr, wr_word         row write port, wr_addr relative to output pointer
//   busy, done                      status: busy in RUN/FLUSH, done one-cycle pulse
//   input_memory_pointer,
//   output_memory_pointer           current read / write buffer bases
module act_mem_output_writer #(
  parameter int N_DIM_ARRAY             = 8,
  parameter int N_DIM_ARRAY_LOG         = 3,
  parameter int ACT_DATA_WIDTH          = 8,
  parameter int INPUT_CHANNEL_ADDR_SIZE = 12
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [INPUT_CHANNEL_ADDR_SIZE-1:0]    cfg_num_elems,
  input  logic                                  cfg_vector_mode,
  input  logic                                  cfg_swap,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] in_data,
  output logic                                  wr_en,
  output logic [INPUT_CHANNEL_ADDR_SIZE-1:0]    wr_addr,
  output logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] wr_word,
  output logic                                  busy,
  output logic                                  done,
  output logic [INPUT_CHANNEL_ADDR_SIZE-1:0]    input_memory_pointer,
  output logic [INPUT_CHANNEL_ADDR_SIZE-1:0]    output_memory_pointer
);

  localparam int W        = ACT_DATA_WIDTH;
  localparam int A        = INPUT_CHANNEL_ADDR_SIZE;
  localparam int DW       = N_DIM_ARRAY * ACT_DATA_WIDTH;
  // Row index space covers half the memory (one buffer); MSB of A picks the buffer.
  localparam int ROW_BITS = A - 1 - N_DIM_ARRAY_LOG;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                     state, state_nxt;
  logic [A-1:0]               remaining;
  logic                       vec_mode;
  logic                       swap_lat;
  logic [N_DIM_ARRAY_LOG-1:0] pack_cnt;
  logic [DW-1:0]              pack_reg;
  logic [ROW_BITS-1:0]        row_cnt;

  logic                       start_ok;
  logic                       accept;
  logic [A-1:0]               consume;
  logic                       last_beat;
  logic                       emit;
  logic                       swap_now;
  logic [DW-1:0]              row_dat;

  assign start_ok = (state == IDLE) && start;
  assign in_ready = (state == RUN) && (remaining != '0);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == RUN) || (state == FLUSH);
  assign done     = (state == DONE);

  // Vector beats consume a full row, except the tail which consumes what is left.
  assign consume   = vec_mode ? ((remaining >= A'(N_DIM_ARRAY)) ? A'(N_DIM_ARRAY) : remaining)
                              : A'(1);
  assign last_beat = (consume == remaining);
  assign emit      = accept && (vec_mode || (pack_cnt == N_DIM_ARRAY_LOG'(N_DIM_ARRAY - 1))
                                         || last_beat);

  // Empty layers swap straight from IDLE using live cfg; normal layers use the latched flag.
  assign swap_now = (start_ok && (cfg_num_elems == '0) && cfg_swap) ||
                    ((state == FLUSH) && swap_lat);

  // Row candidate: vector beat with tail lanes masked, or pack register with the
  // incoming scalar merged into lane pack_cnt. Unfilled pack lanes are already 0.
  always_comb begin
    row_dat = '0;
    for (int k = 0; k < N_DIM_ARRAY; k++) begin
      if (vec_mode) begin
        if (A'(k) < remaining) row_dat[k*W +: W] = in_data[k*W +: W];
      end else if (N_DIM_ARRAY_LOG'(k) == pack_cnt) begin
        row_dat[k*W +: W] = in_data[W-1:0];
      end else begin
        row_dat[k*W +: W] = pack_reg[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cfg_num_elems == '0) ? DONE : RUN;
      RUN:     if (accept && last_beat) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en                 <= 1'b0;
      wr_addr               <= '0;
      wr_word               <= '0;
      remaining             <= '0;
      vec_mode              <= 1'b0;
      swap_lat              <= 1'b0;
      pack_cnt              <= '0;
      pack_reg              <= '0;
      row_cnt               <= '0;
      input_memory_pointer  <= '0;
      output_memory_pointer <= A'(1) << (A - 1);
    end else begin
      wr_en <= emit;
      if (emit) begin
        wr_word <= row_dat;
        wr_addr <= A'(row_cnt);
        row_cnt <= row_cnt + 1'b1;  // wraps within one buffer on overflow
      end

      if (start_ok) begin
        remaining <= cfg_num_elems;
        vec_mode  <= cfg_vector_mode;
        swap_lat  <= cfg_swap;
        pack_cnt  <= '0;
        pack_reg  <= '0;
        row_cnt   <= '0;
      end

      if (accept) begin
        remaining <= remaining - consume;
        if (!vec_mode) begin
          pack_reg <= emit ? '0 : row_dat;
          pack_cnt <= emit ? '0 : pack_cnt + 1'b1;
        end
      end

      if (swap_now) begin
        input_memory_pointer  <= output_memory_pointer;
        output_memory_pointer <= input_memory_pointer;
      end
    end
  end

endmodule

// File: tb/tb_act_mem_output_writer.sv
module tb_act_mem_output_writer;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int A  = 12;
  localparam int DW = N * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [A-1:0]  cfg_num_elems = '0;
  logic          cfg_vector_mode = 1'b0;
  logic          cfg_swap = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, wr_en, busy, done;
  logic [A-1:0]  wr_addr, input_memory_pointer, output_memory_pointer;
  logic [DW-1:0] wr_word;

  act_mem_output_writer #(
    .N_DIM_ARRAY(N), .N_DIM_ARRAY_LOG(3), .ACT_DATA_WIDTH(W), .INPUT_CHANNEL_ADDR_SIZE(A)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_num_elems(cfg_num_elems),
    .cfg_vector_mode(cfg_vector_mode), .cfg_swap(cfg_swap), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_word(wr_word), .busy(busy), .done(done),
    .input_memory_pointer(input_memory_pointer), .output_memory_pointer(output_memory_pointer)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {int cyc; logic [A-1:0] addr; logic [DW-1:0] word;} wexp_t;
  typedef struct {int cyc; logic [A-1:0] ip; logic [A-1:0] op;} dexp_t;
  wexp_t wq[$];
  dexp_t dq[$];
  wexp_t we;
  dexp_t de;

  // Reference pointers, updated from the layer-level rules.
  logic [A-1:0] m_in  = 12'h000;
  logic [A-1:0] m_out = 12'h800;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write and every done pulse must match the next expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: addr %h word %h (cycle %0d)", wr_addr, wr_word, cyc);
        end else begin
          we = wq.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(we.cyc));
          chk("wr_addr", 64'(wr_addr), 64'(we.addr));
          chk("wr_word", wr_word, we.word);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: (cycle %0d)", cyc);
        end else begin
          de = dq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(de.cyc));
          chk("done_in_ptr", 64'(input_memory_pointer), 64'(de.ip));
          chk("done_out_ptr", 64'(output_memory_pointer), 64'(de.op));
        end
      end
    end
  end

  // gap_max < 0 selects the fixed valid pattern 1,0,1,1,...
  task automatic run_layer(input int num, input bit vec, input bit swp, input int gap_max,
                           input bit seq, input bit extra);
    logic [DW-1:0] beats[$];
    logic [W-1:0]  elems[$];
    logic [DW-1:0] rows[$];
    logic [DW-1:0] b;
    logic [DW-1:0] r;
    logic [A-1:0]  t;
    int nb, g, row, w;
    bit completes;
    nb = vec ? (num + N - 1) / N : num;
    for (int i = 0; i < nb; i++) begin
      b = {$urandom, $urandom};
      if (seq) b[W-1:0] = W'(i + 1);
      beats.push_back(b);
      if (vec) begin
        for (int k = 0; k < N; k++) if (elems.size() < num) elems.push_back(b[k*W +: W]);
      end else begin
        elems.push_back(b[W-1:0]);
      end
    end
    // Both modes reduce to: the element stream chopped into N-wide rows, zero-filled.
    for (int ri = 0; ri * N < num; ri++) begin
      r = '0;
      for (int k = 0; k < N; k++) if (ri * N + k < num) r[k*W +: W] = elems[ri*N + k];
      rows.push_back(r);
    end
    if (swp) begin t = m_in; m_in = m_out; m_out = t; end

    @(negedge clk);
    start = 1'b1; cfg_num_elems = A'(num); cfg_vector_mode = vec; cfg_swap = swp;
    if (num == 0) dq.push_back('{cyc + 1, m_in, m_out});
    @(negedge clk);
    start = 1'b0; cfg_num_elems = A'($urandom); cfg_vector_mode = ~vec; cfg_swap = ~swp;
    if (num > 0) chk("busy_after_start", 64'(busy), 64'(1));

    for (int i = 0; i < nb; i++) begin
      if (gap_max < 0) g = (i % 3 == 1) ? 1 : 0;
      else             g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      in_valid = 1'b0;
      repeat (g) @(negedge clk);
      in_valid = 1'b1; in_data = beats[i];
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      if (!in_ready) begin
        total++; bad++;
        $display("FAIL accept_timeout: beat %0d of layer num=%0d", i, num);
        in_valid = 1'b0;
        return;
      end
      completes = vec || (i % N == N - 1) || (i == num - 1);
      row = vec ? i : i / N;
      if (completes) wq.push_back('{cyc + 1, A'(row % 256), rows[row]});
      if (i == nb - 1) dq.push_back('{cyc + 2, m_in, m_out});
      @(negedge clk);
    end
    in_valid = 1'b0;

    if (extra) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom};
      for (int k = 0; k < 3; k++) begin
        chk("extra_beat_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
      end
      in_valid = 1'b0;
    end

    w = 0;
    while ((wq.size() != 0 || dq.size() != 0) && w < 30) begin @(negedge clk); w++; end
    chk("layer_pending", 64'(wq.size() + dq.size()), 64'(0));
    chk("ptr_in_after", 64'(input_memory_pointer), 64'(m_in));
    chk("ptr_out_after", 64'(output_memory_pointer), 64'(m_out));
  endtask

  initial begin
    int w;
    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ptr", 64'(input_memory_pointer), 64'(12'h000));
    chk("rst_out_ptr", 64'(output_memory_pointer), 64'(12'h800));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_done", 64'(done), 64'(0));
    chk("idle_in_ready", 64'(in_ready), 64'(0));

    // Scalar full row, partial row with surplus beat, vector with stalls
    run_layer(8, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    run_layer(10, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    run_layer(20, 1'b1, 1'b0, -1, 1'b0, 1'b0);

    // Empty layers with swap, twice
    run_layer(0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    chk("swap1_in", 64'(input_memory_pointer), 64'(12'h800));
    run_layer(0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    chk("swap2_in", 64'(input_memory_pointer), 64'(12'h000));

    // Abort: swapped pointers, partial scalar layer, reset mid-layer
    run_layer(0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; cfg_num_elems = 12'd10; cfg_vector_mode = 1'b0; cfg_swap = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom};
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      chk("abort_beat_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1; m_in = 12'h000; m_out = 12'h800;
    @(negedge clk);
    chk("abort_in_ptr", 64'(input_memory_pointer), 64'(12'h000));
    chk("abort_out_ptr", 64'(output_memory_pointer), 64'(12'h800));
    chk("abort_busy", 64'(busy), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_in_ptr_late", 64'(input_memory_pointer), 64'(12'h000));
    run_layer(9, 1'b0, 1'b0, 1, 1'b1, 1'b0);

    // Vector edge sizes, then random layers
    run_layer(16, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    run_layer(1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_layer(1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    for (int t = 0; t < 10; t++)
      run_layer($urandom_range(40, 1), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                2, 1'b0, 1'b0);
    // Row address wraps after 256 rows of one buffer
    run_layer(2056, 1'b1, 1'b0, 0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("final_queues_empty", 64'(wq.size() + dq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
